// File: rtl/capture_readout.sv
// Streams a completed capture buffer to the UART TX as a framed byte sequence:
// header, 2-byte sample count, then each sample as a hi/lo byte pair.
module capture_readout #(
   parameter int          DATA_WIDTH  = 12,
   parameter int          ADDR_WIDTH  = 9,
   parameter int          DEPTH       = 512,
   parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH:0]   i_sample_count,
   input  logic [DATA_WIDTH-1:0] i_read_data,
   input  logic                  i_tx_ready,
   output logic [ADDR_WIDTH-1:0] o_read_address,
   output logic                  o_read_en,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_en,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int CW = ADDR_WIDTH + 1;

   typedef enum logic [3:0] {
      IDLE, SEND_HDR, SEND_CNT_HI, SEND_CNT_LO, RD_REQ, RD_LATCH,
      SEND_S_HI, SEND_S_LO, GUARD, DONE
   } state_t;

   state_t                state_q, state_nxt, ret_q, ret_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CW-1:0]         count_q;
   logic [DATA_WIDTH-1:0] sample_q;
   logic [7:0]            tx_data_q;
   logic [7:0]            tx_byte;
   logic                  is_send;
   state_t                succ;

   logic [15:0]   count_ext, sample_ext;
   logic [CW-1:0] addr_inc, start_count;
   logic          last_sample;

   assign count_ext   = 16'(count_q);
   assign sample_ext  = 16'(sample_q);
   assign addr_inc    = CW'(addr_q) + CW'(1);
   assign last_sample = (addr_inc == count_q);
   assign start_count = (i_sample_count > CW'(DEPTH)) ? CW'(DEPTH) : i_sample_count;

   always_comb begin
      state_nxt = state_q;
      ret_nxt   = ret_q;
      tx_byte   = 8'h00;
      is_send   = 1'b0;
      succ      = IDLE;
      case (state_q)
         IDLE:        if (i_start) state_nxt = SEND_HDR;
         SEND_HDR:    begin is_send = 1'b1; tx_byte = HEADER_BYTE;      succ = SEND_CNT_HI; end
         SEND_CNT_HI: begin is_send = 1'b1; tx_byte = count_ext[15:8];  succ = SEND_CNT_LO; end
         SEND_CNT_LO: begin
            is_send = 1'b1;
            tx_byte = count_ext[7:0];
            succ    = (count_q == '0) ? DONE : RD_REQ;
         end
         RD_REQ:      state_nxt = RD_LATCH;
         RD_LATCH:    state_nxt = SEND_S_HI;
         SEND_S_HI:   begin is_send = 1'b1; tx_byte = sample_ext[15:8]; succ = SEND_S_LO; end
         SEND_S_LO:   begin
            is_send = 1'b1;
            tx_byte = sample_ext[7:0];
            succ    = last_sample ? DONE : RD_REQ;
         end
         GUARD:       state_nxt = ret_q;
         DONE:        state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
      // GUARD masks the TX's ready drop right after it accepts a byte
      if (is_send && i_tx_ready) begin
         state_nxt = GUARD;
         ret_nxt   = succ;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         ret_q     <= IDLE;
         addr_q    <= '0;
         count_q   <= '0;
         sample_q  <= '0;
         tx_data_q <= '0;
      end else begin
         state_q <= state_nxt;
         ret_q   <= ret_nxt;
         if (state_q == IDLE && i_start) begin
            count_q <= start_count;
            addr_q  <= '0;
         end
         if (state_q == RD_LATCH) sample_q <= i_read_data;
         if (o_tx_en) tx_data_q <= tx_byte;
         if (o_tx_en && state_q == SEND_S_LO && !last_sample) addr_q <= addr_q + 1'b1;
      end
   end

   assign o_tx_en        = is_send & i_tx_ready;
   assign o_tx_data      = o_tx_en ? tx_byte : tx_data_q;
   assign o_read_en      = (state_q == RD_REQ);
   assign o_read_address = addr_q;
   assign o_busy         = (state_q != IDLE);
   assign o_done         = (state_q == DONE);

endmodule

// File: tb/tb_capture_readout.sv
// Directed/randomized bench for capture_readout: synchronous RAM and UART TX
// models, byte frames checked against a queue-based frame model.
module tb_capture_readout;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic [9:0]  i_sample_count = '0;
   logic [11:0] i_read_data = '0;
   logic        i_tx_ready = 1'b1;
   logic [8:0]  o_read_address;
   logic        o_read_en;
   logic [7:0]  o_tx_data;
   logic        o_tx_en;
   logic        o_busy;
   logic        o_done;

   capture_readout dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_sample_count(i_sample_count),
      .i_read_data(i_read_data), .i_tx_ready(i_tx_ready), .o_read_address(o_read_address),
      .o_read_en(o_read_en), .o_tx_data(o_tx_data), .o_tx_en(o_tx_en), .o_busy(o_busy),
      .o_done(o_done)
   );

   initial forever #5 i_clk = ~i_clk;

   logic [11:0] mem [512];
   int vectors = 0;
   int miscompares = 0;

   // synchronous RAM, one cycle latency
   always @(posedge i_clk) if (o_read_en) i_read_data <= mem[o_read_address];

   // monitor: records bytes and reads, counts protocol violations
   logic [7:0] rx_q [$];
   int         rd_q [$];
   int         done_cnt = 0, bad_ready = 0, bad_gap = 0;
   logic       prev_en = 1'b0, saw_tx = 1'b0;
   always @(negedge i_clk) begin
      saw_tx = o_tx_en;
      if (!i_rst) begin
         if (o_tx_en) begin
            rx_q.push_back(o_tx_data);
            if (!i_tx_ready) bad_ready++;
            if (prev_en) bad_gap++;
         end
         prev_en = o_tx_en;
         if (o_read_en) rd_q.push_back(int'(o_read_address));
         if (o_done) done_cnt++;
      end else prev_en = 1'b0;
   end

   // TX model: optionally drops ready for 1..20 cycles after each byte
   bit drop_mode = 1'b0;
   int hold = 0;
   always @(posedge i_clk) begin
      #1;
      if (!drop_mode) begin
         hold = 0;
         i_tx_ready = 1'b1;
      end else if (saw_tx) begin
         hold = $urandom_range(1, 20);
         i_tx_ready = 1'b0;
      end else if (hold > 0) begin
         hold--;
         i_tx_ready = (hold == 0);
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // frame model built straight from the byte-order rules
   logic [7:0] exp_q [$];
   task automatic build_expected(input int req, output int n);
      n = (req > 512) ? 512 : req;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'((n / 256) % 256));
      exp_q.push_back(8'(n % 256));
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(8'(mem[i] / 256));
         exp_q.push_back(8'(mem[i] % 256));
      end
   endtask

   task automatic run_frame(input string tag, input int req, input bit spam);
      int rx_base = rx_q.size();
      int rd_base = rd_q.size();
      int d_base = done_cnt, br = bad_ready, bg = bad_gap;
      int n, cyc;
      build_expected(req, n);
      @(posedge i_clk); #2;
      i_start = 1'b1;
      i_sample_count = req[9:0];
      @(posedge i_clk); #2;
      i_start = 1'b0;
      cyc = 0;
      while (done_cnt == d_base && cyc < 30000) begin
         @(posedge i_clk); #2;
         cyc++;
         if (spam) begin
            i_start = 1'($urandom_range(0, 1));
            i_sample_count = 10'($urandom_range(0, 1023));
         end
      end
      i_start = 1'b0;
      check({tag, "_timeout"}, int'(cyc < 30000), 1);
      repeat (2) @(posedge i_clk);
      #2;
      check({tag, "_done_pulses"}, done_cnt - d_base, 1);
      check({tag, "_busy_after"}, int'(o_busy), 0);
      check({tag, "_byte_count"}, rx_q.size() - rx_base, exp_q.size());
      for (int i = 0; i < exp_q.size() && rx_base + i < rx_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), int'(rx_q[rx_base + i]), int'(exp_q[i]));
      check({tag, "_read_count"}, rd_q.size() - rd_base, n);
      for (int i = 0; i < n && rd_base + i < rd_q.size(); i++)
         check($sformatf("%s_addr%0d", tag, i), rd_q[rd_base + i], i);
      check({tag, "_tx_while_not_ready"}, bad_ready - br, 0);
      check({tag, "_back_to_back_tx"}, bad_gap - bg, 0);
   endtask

   initial begin
      int rd_base, cyc;
      for (int i = 0; i < 512; i++) mem[i] = 12'($urandom);
      mem[0] = 12'hABC;
      mem[1] = 12'h123;

      repeat (3) @(posedge i_clk);
      #2;
      check("rst_tx_en", int'(o_tx_en), 0);
      check("rst_tx_data", int'(o_tx_data), 0);
      check("rst_read_en", int'(o_read_en), 0);
      check("rst_read_addr", int'(o_read_address), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_done", int'(o_done), 0);
      i_rst = 1'b0;

      run_frame("basic", 2, 1'b0);
      run_frame("zero", 0, 1'b0);
      run_frame("clamp", 600, 1'b0);
      drop_mode = 1'b1;
      run_frame("drop2", 2, 1'b0);
      run_frame("drop_rand", $urandom_range(3, 9), 1'b0);
      drop_mode = 1'b0;
      run_frame("spam", 5, 1'b1);
      run_frame("after_spam", 3, 1'b0);

      // reset in the middle of sample 1 of a 4-sample frame
      rd_base = rd_q.size();
      @(posedge i_clk); #2;
      i_start = 1'b1;
      i_sample_count = 10'd4;
      @(posedge i_clk); #2;
      i_start = 1'b0;
      cyc = 0;
      while (rd_q.size() < rd_base + 2 && cyc < 1000) begin
         @(posedge i_clk); #2;
         cyc++;
      end
      check("midrst_reached_s1", int'(cyc < 1000), 1);
      i_rst = 1'b1;
      #1;
      check("midrst_busy", int'(o_busy), 0);
      check("midrst_read_en", int'(o_read_en), 0);
      check("midrst_read_addr", int'(o_read_address), 0);
      check("midrst_tx_data", int'(o_tx_data), 0);
      check("midrst_tx_en", int'(o_tx_en), 0);
      check("midrst_done", int'(o_done), 0);
      @(posedge i_clk); #2;
      i_rst = 1'b0;
      run_frame("post_rst", 4, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
